ifu_fetchq: RTL
===============

# ifu_fetchq

Parametrised instruction-fetch unit with an in-order fetch queue, for the pipelined core. Sits between instruction memory and decode. It generates sequential fetch PCs and issues requests over a valid/ready handshake, with up to DEPTH requests outstanding. Returned instructions are buffered in program order and presented to decode over a valid/ready handshake. A redirect from execute discards all queued and in-flight fetches.

## Interface
- XLEN, 64, PC/address width
- RESET_PC, XLEN'h8000_0000, first fetch address after reset
- DEPTH, 4, queue entries = max outstanding fetches; power of 2, ≥2
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset; one clock, reset is asynchronous and active-low
- redirect_valid  in  1  redirect fetch (jump/branch/trap taken)
- redirect_pc  in  XLEN  new fetch PC
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  instruction returned (in request order)
- imem_rsp_instr  in  32  returned instruction
- ifu_valid  out  1  head instruction valid to decode
- ifu_ready  in  1  decode accepts (low = hazard stall)
- ifu_pc  out  XLEN  PC of head instruction
- ifu_instr  out  32  head instruction
- ifu_snxt_pc  out  XLEN  ifu_pc + 4
- fq_count  out  clog2(DEPTH)+1  allocated queue entries

## Operation
- State: fetch_pc; DEPTH entries {pc, instr, filled}; pointers head, fill, tail (clog2(DEPTH) bits, wrap modulo DEPTH); alloc count; drop_cnt (clog2(DEPTH)+1 bits).
- Issue: imem_req_valid = !redirect_valid && (alloc + drop_cnt < DEPTH); imem_req_addr = fetch_pc.
- On req handshake: entry[tail] <= {fetch_pc, -, filled=0}; tail++; alloc++; fetch_pc += 4 (mod 2^XLEN).
- Response: if drop_cnt != 0, instr discarded and drop_cnt--. Otherwise entry[fill].instr <= imem_rsp_instr, filled <= 1, fill++.
- Output: ifu_valid = !redirect_valid && alloc != 0 && entry[head].filled. ifu_pc/ifu_instr come from entry[head]; ifu_snxt_pc = ifu_pc + 4.
- Pop on ifu_valid && ifu_ready: head++, alloc--, filled cleared.
- Redirect (highest priority):
  - fetch_pc <= redirect_pc.
  - head, fill, tail <= 0; alloc <= 0; all filled <= 0.
  - drop_cnt <= drop_cnt + (alloc − filled entries) − (1 if a response arrives this cycle and drop_cnt was 0 … the response is dropped either way).
  - Exact rule: every response accepted in the redirect cycle is dropped. drop_cnt_next = outstanding requests after that response.
  - No issue and no pop occur in the redirect cycle.
- Invariant: outstanding requests (alloc − filled + drop_cnt) ≤ DEPTH.
- Responses with zero outstanding requests are illegal; the bench asserts on them.

## Timing
- Reset (async assert, sync-released use): fetch_pc=RESET_PC, pointers/alloc/drop_cnt=0, entries zero.
  - Outputs in reset: imem_req_valid=1, imem_req_addr=RESET_PC, ifu_valid=0, ifu_pc=0, ifu_instr=0, ifu_snxt_pc=4, fq_count=0.
- Memory response earliest 1 cycle after its request handshake; ifu_valid rises the cycle after the response (no bypass). Minimum req-to-decode latency: 2 cycles.
- Full (alloc + drop_cnt = DEPTH): imem_req_valid=0. A pop in cycle N allows issue in N+1.
- Same-cycle issue, fill and pop on distinct or equal slots are all legal. alloc_next = alloc + issue − pop.
- Fill of the head slot and pop of head cannot coincide; fill is visible next cycle.
- ifu_ready low holds all ifu_* outputs stable; the queue keeps filling until full.
- Reset asserted mid-operation: all state is cleared immediately. The memory side must also be reset (no stale responses).

## Test plan
- Reset, then memory with 1-cycle latency and ifu_ready=1 -> requests 0x80000000, 0x80000004, … every cycle; ifu_pc sequence matches, first ifu_valid 2 cycles after first handshake; steady throughput 1/cycle.
- ifu_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests accepted, fq_count=4, imem_req_valid=0, ifu_pc held at 0x80000000; release -> 4 pops in 4 cycles then resume.
- 3 requests outstanding (latency 5), redirect to 0x80001000 -> drop_cnt=3, next 3 responses discarded, first delivered ifu_pc=0x80001000; no stale instr ever reaches decode.
- Redirect in the same cycle as a response and as ifu_valid&&ifu_ready -> response dropped, no pop, ifu_valid=0, imem_req_valid=0 that cycle.
- Back-to-back redirects (0x80002000 then 0x80003000) with in-flight fetches -> outstanding never exceeds DEPTH, only 0x80003000 stream delivered.
- XLEN=32, DEPTH=8, fetch_pc 0xFFFFFFFC -> next request 0x00000000; fq_count reaches 8 under stall.

Source files
------------

// File: rtl/ifu_fetchq_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response channel and decode-side channel.
// The master modport belongs to the fetch unit; the slave modport belongs to memory, execute and decode.
interface ifu_fetchq_if #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_instr;
   logic            ifu_valid;
   logic            ifu_ready;
   logic [XLEN-1:0] ifu_pc;
   logic [31:0]     ifu_instr;
   logic [XLEN-1:0] ifu_snxt_pc;
   logic [CW-1:0]   fq_count;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_instr, ifu_ready,
      output imem_req_valid, imem_req_addr, ifu_valid, ifu_pc, ifu_instr, ifu_snxt_pc, fq_count
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_instr, ifu_ready,
      input  imem_req_valid, imem_req_addr, ifu_valid, ifu_pc, ifu_instr, ifu_snxt_pc, fq_count
   );
endinterface

// File: rtl/ifu_fetchq.sv
// Instruction-fetch unit: sequential PC generation, up to DEPTH outstanding fetches, in-order queue to decode.
// A redirect flushes the queue and counts still-in-flight responses so they are dropped on return.
module ifu_fetchq #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
   parameter int              DEPTH    = 4
) (
   input  logic          clk,
   input  logic          rstn,
   ifu_fetchq_if.master  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0]  fetch_pc_r;
   logic [XLEN-1:0]  pc_r    [DEPTH];
   logic [31:0]      instr_r [DEPTH];
   logic [DEPTH-1:0] filled_r;
   logic [AW-1:0]    head_r;
   logic [AW-1:0]    fill_r;
   logic [AW-1:0]    tail_r;
   logic [CW-1:0]    alloc_r;
   logic [CW-1:0]    drop_cnt_r;

   logic             issue_s;
   logic             pop_s;
   logic             fill_s;
   logic             drop_s;
   logic [CW-1:0]    filled_cnt_s;
   logic [CW-1:0]    redir_drop_s;
   logic [DEPTH-1:0] filled_next_s;

   // Outstanding requests (allocated or awaiting drop) may never exceed DEPTH.
   assign bus.imem_req_valid = !bus.redirect_valid &&
                               (({1'b0, alloc_r} + {1'b0, drop_cnt_r}) < (CW+1)'(DEPTH));
   assign bus.imem_req_addr  = fetch_pc_r;
   assign bus.ifu_valid      = !bus.redirect_valid && (alloc_r != CW'(0)) && filled_r[head_r];
   assign bus.ifu_pc         = pc_r[head_r];
   assign bus.ifu_instr      = instr_r[head_r];
   assign bus.ifu_snxt_pc    = pc_r[head_r] + XLEN'(4);
   assign bus.fq_count       = alloc_r;

   assign issue_s = bus.imem_req_valid && bus.imem_req_ready;
   assign pop_s   = bus.ifu_valid && bus.ifu_ready;
   assign fill_s  = bus.imem_rsp_valid && (drop_cnt_r == CW'(0));
   assign drop_s  = bus.imem_rsp_valid && (drop_cnt_r != CW'(0));

   // Filled-slot bookkeeping: fill and pop never target the same slot in one cycle.
   always_comb begin
      filled_cnt_s  = CW'(0);
      filled_next_s = filled_r;
      for (int i = 0; i < DEPTH; i++) begin
         filled_cnt_s     = filled_cnt_s + CW'(filled_r[i]);
         filled_next_s[i] = (fill_s && (fill_r == AW'(i))) ? 1'b1 :
                            (pop_s  && (head_r == AW'(i))) ? 1'b0 : filled_r[i];
      end
   end

   // Every unfilled request plus any pending drops stays outstanding; a response this cycle consumes one.
   assign redir_drop_s = drop_cnt_r + alloc_r - filled_cnt_s - CW'(bus.imem_rsp_valid);

   // Queue, pointer and fetch-PC state; redirect overrides issue, fill and pop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_pc_r <= RESET_PC;
         head_r     <= AW'(0);
         fill_r     <= AW'(0);
         tail_r     <= AW'(0);
         alloc_r    <= CW'(0);
         drop_cnt_r <= CW'(0);
         filled_r   <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            pc_r[i]    <= XLEN'(0);
            instr_r[i] <= 32'h0;
         end
      end else if (bus.redirect_valid) begin
         fetch_pc_r <= bus.redirect_pc;
         head_r     <= AW'(0);
         fill_r     <= AW'(0);
         tail_r     <= AW'(0);
         alloc_r    <= CW'(0);
         drop_cnt_r <= redir_drop_s;
         filled_r   <= {DEPTH{1'b0}};
      end else begin
         if (issue_s) begin
            pc_r[tail_r] <= fetch_pc_r;
            tail_r       <= tail_r + AW'(1);
            fetch_pc_r   <= fetch_pc_r + XLEN'(4);
         end
         if (fill_s) begin
            instr_r[fill_r] <= bus.imem_rsp_instr;
            fill_r          <= fill_r + AW'(1);
         end
         if (drop_s) begin
            drop_cnt_r <= drop_cnt_r - CW'(1);
         end
         if (pop_s) begin
            head_r <= head_r + AW'(1);
         end
         alloc_r  <= alloc_r + CW'(issue_s) - CW'(pop_s);
         filled_r <= filled_next_s;
      end
   end
endmodule
